// File: rtl/display_arbiter_if.sv
// Bus between the display sources (clock/alarm counters, setting screen, message
// requester) and the display arbiter, plus the arbiter's outputs to the decoder.
//   master : source side, drives segment data, setting controls and msg_req.
//   slave  : arbiter side, drives decoder data, ownership status and pulses.
interface display_arbiter_if;
  logic [63:0] time_seg;     // live time segments, active-low, digit 7 in [63:56]
  logic [63:0] set_seg;      // setting-screen segments
  logic [3:0]  set_index;    // digit under adjustment
  logic        set_active;   // level: setting mode
  logic        set_key;      // pulse: key activity in setting mode
  logic [63:0] msg_seg;      // overlay segments, sampled at grant
  logic        msg_req;      // level request, held until msg_gnt
  logic        msg_gnt;      // pulse: request accepted
  logic [63:0] display_time; // to decoder
  logic [3:0]  index;        // to decoder
  logic        adjust;       // to decoder
  logic [1:0]  owner;        // 0=TIME, 1=SET, 2=MSG
  logic        msg_busy;     // high while overlay shown
  logic        set_timeout;  // pulse: idle-timeout exit from setting

  modport master (
    output time_seg, set_seg, set_index, set_active, set_key, msg_seg, msg_req,
    input  msg_gnt, display_time, index, adjust, owner, msg_busy, set_timeout
  );

  modport slave (
    input  time_seg, set_seg, set_index, set_active, set_key, msg_seg, msg_req,
    output msg_gnt, display_time, index, adjust, owner, msg_busy, set_timeout
  );
endinterface

// File: rtl/display_arbiter.sv
// Display arbiter: shares the 8-digit 7-segment decoder between live time, the
// time-setting screen and a transient message overlay. Priority MSG > SET > TIME.
// Ports:
//   CP_1KHz : 1 kHz system clock
//   CR      : synchronous active-high reset
//   bus     : display_arbiter_if.slave (source data/controls in, decoder data,
//             owner, msg_gnt, msg_busy, set_timeout out); all outputs registered.
module display_arbiter #(
  parameter int unsigned HOLD_MS    = 2000,
  parameter int unsigned TIMEOUT_MS = 10000
) (
  input logic               CP_1KHz,
  input logic               CR,
  display_arbiter_if.slave  bus
);

  localparam logic [15:0] HoldLast = 16'(HOLD_MS - 1);
  localparam logic [15:0] IdleLast = 16'(TIMEOUT_MS - 1);

  typedef enum logic [1:0] {StTime = 2'd0, StSet = 2'd1, StMsg = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] idle_q, idle_d;
  logic        lockout_q, lockout_d;
  logic [63:0] msg_reg_q, msg_reg_d;
  logic        gnt_q, gnt_d;
  logic        timeout_q, timeout_d;
  logic [63:0] disp_q, disp_d;
  logic [3:0]  index_q, index_d;
  logic        adjust_q, adjust_d;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    idle_d    = idle_q;
    // Lockout only persists while the user keeps set_active asserted.
    lockout_d = bus.set_active ? lockout_q : 1'b0;
    msg_reg_d = msg_reg_q;
    gnt_d     = 1'b0;
    timeout_d = 1'b0;

    unique case (state_q)
      StTime: begin
        idle_d = '0;
        if (bus.msg_req) begin
          state_d   = StMsg;
          gnt_d     = 1'b1;
          msg_reg_d = bus.msg_seg;
          hold_d    = '0;
        end else if (bus.set_active && !lockout_q) begin
          state_d = StSet;
        end
      end
      StSet: begin
        if (bus.msg_req) begin
          // Preemption keeps idle_q frozen so the timeout resumes afterwards.
          state_d   = StMsg;
          gnt_d     = 1'b1;
          msg_reg_d = bus.msg_seg;
          hold_d    = '0;
        end else if (!bus.set_active) begin
          state_d = StTime;
        end else if (bus.set_key) begin
          idle_d = '0;
        end else if (idle_q == IdleLast) begin
          timeout_d = 1'b1;
          lockout_d = 1'b1;
          state_d   = StTime;
        end else begin
          idle_d = idle_q + 16'd1;
        end
      end
      StMsg: begin
        // Requests are ignored here; a held request is granted from TIME/SET next cycle.
        if (hold_q == HoldLast) begin
          state_d = (bus.set_active && !lockout_q) ? StSet : StTime;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      default: state_d = StTime;
    endcase

    // Output mux follows the next state so ownership and data change together.
    disp_d   = bus.time_seg;
    index_d  = '0;
    adjust_d = 1'b0;
    case (state_d)
      StSet: begin
        disp_d   = bus.set_seg;
        index_d  = bus.set_index;
        adjust_d = 1'b1;
      end
      StMsg:   disp_d = msg_reg_d;
      default: ;
    endcase
  end

  always_ff @(posedge CP_1KHz) begin
    if (CR) begin
      state_q   <= StTime;
      hold_q    <= '0;
      idle_q    <= '0;
      lockout_q <= 1'b0;
      msg_reg_q <= '1;
      gnt_q     <= 1'b0;
      timeout_q <= 1'b0;
      disp_q    <= '1;
      index_q   <= '0;
      adjust_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      idle_q    <= idle_d;
      lockout_q <= lockout_d;
      msg_reg_q <= msg_reg_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
      disp_q    <= disp_d;
      index_q   <= index_d;
      adjust_q  <= adjust_d;
    end
  end

  assign bus.display_time = disp_q;
  assign bus.index        = index_q;
  assign bus.adjust       = adjust_q;
  assign bus.owner        = state_q;
  assign bus.msg_busy     = (state_q == StMsg);
  assign bus.msg_gnt      = gnt_q;
  assign bus.set_timeout  = timeout_q;

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the 8-digit multiplexed 7-segment decoder between three sources: live time (default), the time-setting screen, and a transient message overlay (alarm/chime text).
- Selects the owner, latches overlay content, times the overlay and the setting-screen idle timeout.
- Drives the decoder's display_time/index/adjust inputs.
- Sits between the clock/alarm counters and the decoder, in the CP_1KHz domain.

Parameters:
- HOLD_MS, 2000, overlay display duration in CP_1KHz cycles (1..65535).
- TIMEOUT_MS, 10000, setting-screen idle cycles before forced exit (1..65535).

Ports:
- CP_1KHz  input  1  system clock, 1 kHz.
- CR  input  1  reset; synchronous, active-high.
- time_seg  input  64  live time segment codes, 8 digits x 8 bits, active-low segments, digit 7 in [63:56].
- set_seg  input  64  setting-screen segment codes, same format.
- set_index  input  4  digit under adjustment, 0..7.
- set_active  input  1  level: user is in setting mode.
- set_key  input  1  one-cycle pulse: user key activity in setting mode.
- msg_seg  input  64  overlay segment codes; sampled at grant.
- msg_req  input  1  level overlay request; held by requester until msg_gnt.
- msg_gnt  output  1  one-cycle pulse: request accepted, msg_seg latched.
- display_time  output  64  to decoder.
- index  output  4  to decoder.
- adjust  output  1  to decoder; 1 only while the setting screen owns the display.
- owner  output  2  0=TIME, 1=SET, 2=MSG.
- msg_busy  output  1  high while in MSG.
- set_timeout  output  1  one-cycle pulse on idle-timeout exit.

Behaviour:
- All outputs registered. Reset values:
  - display_time=64'hFFFF_FFFF_FFFF_FFFF (all segments off)
  - index=0, adjust=0, owner=0, msg_gnt=0, msg_busy=0, set_timeout=0
  - state=S_TIME, hold_cnt=0, idle_cnt=0, lockout=0
- CR mid-operation aborts overlay and setting immediately, with no gnt or timeout pulse.
- Priority: MSG > SET > TIME.
- S_TIME:
  - msg_req → S_MSG with grant.
  - Otherwise, set_active & !lockout → S_SET with idle_cnt=0.
- S_SET:
  - msg_req → S_MSG with grant; idle_cnt is preserved and paused.
  - !set_active → S_TIME.
  - set_key → idle_cnt=0.
  - Otherwise idle_cnt increments. When idle_cnt==TIMEOUT_MS-1 and no set_key that cycle: set_timeout pulse, lockout=1, → S_TIME.
  - set_key in the same cycle as the terminal count wins: counter clears, no timeout.
- S_MSG:
  - hold_cnt counts 0..HOLD_MS-1. At terminal count, exit to S_SET if set_active & !lockout, else S_TIME.
  - msg_req during S_MSG is not granted. It is granted the cycle after exit if still high, which re-enters S_MSG back-to-back.
- Grant cycle: msg_gnt=1 and msg_seg is captured into msg_reg in the same edge where state becomes S_MSG.
  - msg_busy=1 and owner=2 from the next cycle.
  - The overlay is visible for exactly HOLD_MS cycles.
- lockout clears when set_active is low.
- Output mux, registered, one-cycle latency from the source input:
  - TIME: time_seg live, index=0, adjust=0.
  - SET: set_seg live, index=set_index, adjust=1.
  - MSG: msg_reg, index=0, adjust=0.
- Counters are 16-bit unsigned with no wrap; each stops at its terminal count.
- Simultaneous msg_req and set_active entry from S_TIME: MSG wins. After the overlay, SET is entered if still active.

Test Plan:
- Reset: CR=1 for 2 cycles with arbitrary inputs → display_time=FFFF_FFFF_FFFF_FFFF, owner=0, all pulses 0. Release CR with time_seg=64'hC0F9_A4B0_9992_82F8 → display_time equals it one cycle later, adjust=0.
- Setting screen (TIMEOUT_MS=8): set_active=1, set_index=3, set_seg=64'hC0C0_C0C0_C0C0_C0C0 → owner=1, adjust=1, index=3 next cycle. set_key every 5 cycles for 30 cycles → no set_timeout.
- Timeout (TIMEOUT_MS=8): hold set_active, no keys → set_timeout pulses after 8 SET cycles, owner=0. Stays 0 while set_active=1. Drop and raise set_active → owner=1.
- Overlay (HOLD_MS=4): msg_req=1, msg_seg=64'h8888_8888_8888_8888 from S_TIME → msg_gnt for 1 cycle. Change msg_seg after grant → display still 8888…, owner=2 for exactly 4 cycles, then time_seg.
- Preempt (HOLD_MS=4): in S_SET with idle_cnt=5, raise msg_req → MSG for 4 cycles, then back to SET. Timeout fires 3 SET cycles later, showing idle_cnt was preserved.
- Back-to-back/edge cases: msg_req held through an overlay → second msg_gnt the cycle after the first overlay exits. set_key on the terminal idle cycle → no timeout. CR asserted mid-overlay → owner=0, display all-off next cycle.
